scancode_to_ascii: RTL and testbench
====================================

Name: scancode_to_ascii

Overview:
Consumes PS/2 set-2 scan-code bytes from the keyboard receiver stage and tracks make/break, extended-prefix, Shift and Caps Lock state. Translates make codes of printable and control keys into 7-bit ASCII and queues the characters in a small FIFO. Presents the oldest character to the CPU through an interrupt/acknowledge handshake. Sits between the PS/2 receiver and the CPU bus in the keyboard toplevel.

Parameters:
FIFO_DEPTH, 8, character queue depth; must be a power of two.
ADDR_WIDTH, 3, log2(FIFO_DEPTH).

Ports:
clk  input  1  system clock (27 MHz)
rst  input  1  synchronous, active-high reset
scan_code  input  8  byte from the receiver; valid only when scan_valid=1
scan_valid  input  1  one-cycle strobe: scan_code holds a new byte
scan_err  input  1  one-cycle strobe: the receiver saw a framing or parity error
cpu_ack  input  1  CPU acknowledge level, asynchronous to clk
cpu_intr  output  1  high while the FIFO is non-empty
ascii_out  output  8  character at the FIFO head, bit 7 always 0
overflow  output  1  sticky flag: a character was dropped because the FIFO was full
caps_state  output  1  current Caps Lock toggle state (reserved for a future LED command)

Behaviour:
- Reset values: cpu_intr=0, ascii_out=0x00, overflow=0, caps_state=0, FIFO empty, all prefix and shift flags cleared, ack synchroniser cleared.
- Prefix state:
  - E0 sets ext_pend.
  - F0 sets brk_pend.
  - The next non-prefix byte consumes the key event and clears both flags in the same cycle.
  - scan_err clears both flags. Any byte arriving in the same cycle as scan_err is ignored.
- Modifiers:
  - 0x12 (LShift) and 0x59 (RShift): a make sets shl/shr, a break clears it. shift = shl|shr.
  - 0x58 (Caps Lock): a make toggles caps_state. The break is ignored.
  - All events with ext_pend=1 update no state and produce no character. This includes the E0 12 fake-shift.
- Characters are produced only by non-extended make events. Break events never produce a character. Repeated make codes (typematic) each enqueue a character.
- Letters, with uppercase when shift XOR caps_state:
  - 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m
  - 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z
- Digits, with US shifted symbols when shift=1 (Caps Lock has no effect):
  - 16 1/!, 1E 2/@, 26 3/#, 25 4/$, 2E 5/%
  - 36 6/^, 3D 7/&, 3E 8/*, 46 9/(, 45 0/)
- Control keys, unaffected by modifiers: 29 space 0x20, 5A Enter 0x0D, 66 Backspace 0x08, 0D Tab 0x09, 76 Esc 0x1B.
- Any other code produces nothing.
- Latency:
  - The translation is registered. A byte strobed in cycle N is written to the FIFO at the end of cycle N+1.
  - cpu_intr and ascii_out are registered from FIFO state. For a byte strobed in cycle N into an empty FIFO, cpu_intr=1 and ascii_out=char from cycle N+2.
- CPU handshake:
  - cpu_ack passes through a 2-flop synchroniser followed by rising-edge detection.
  - Each detected rising edge pops one entry. ascii_out shows the next entry, or cpu_intr drops, two cycles after the edge is detected.
  - An ack edge while the FIFO is empty is ignored.
  - Holding ack high pops only once.
- FIFO boundaries:
  - Simultaneous push and pop: both take effect and the count is unchanged. This also applies when the FIFO is full.
  - Push when full with no pop: the character is dropped and overflow is set. overflow clears only on rst.
  - Pointers wrap modulo FIFO_DEPTH. An explicit count register of ADDR_WIDTH+1 bits distinguishes full from empty.
- rst mid-sequence, for example between F0 and the following byte, returns the block to the reset state in the next cycle. Partially received prefixes are discarded.

Test Plan:
- Strobes 1C, F0 1C -> exactly one entry: cpu_intr=1 and ascii_out=0x61 two cycles after the first strobe. The break code enqueues nothing.
- Strobes 12, 1E, F0 12, 1E -> ascii_out 0x40 ('@'); after an ack pulse 0x32 ('2'); after a second ack cpu_intr=0.
- Strobe 58, then 1C, then 12 1C -> caps_state=1; characters 0x41 then 0x61 (Caps Lock XOR Shift).
- Strobes E0 5A, E0 F0 12, then 16, with scan_err asserted after F0 in a separate F0, scan_err, 1C sequence -> only 0x31 and 0x61 enqueued. Extended events and the error are ignored, and 1C is decoded as a make, not a break.
- 9 make strobes of 29 with no ack -> FIFO holds 8 x 0x20 and overflow=1. Then 8 ack pulses -> cpu_intr=0 after the last one, and overflow stays 1.
- Push and ack edge in the same cycle with the FIFO full -> count stays 8 and overflow stays 0. Then assert rst -> all outputs return to reset values one cycle later.

Source files
------------

// File: rtl/scancode_to_ascii.sv
// PS/2 set-2 scan-code decoder: tracks prefixes, Shift and Caps Lock, translates
// make codes to ASCII and queues them for the CPU behind an intr/ack handshake.
module scancode_to_ascii #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       scan_err,
  input  logic       cpu_ack,
  output logic       cpu_intr,
  output logic [7:0] ascii_out,
  output logic       overflow,
  output logic       caps_state
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  localparam logic [1:0] K_NONE   = 2'd0;
  localparam logic [1:0] K_LETTER = 2'd1;
  localparam logic [1:0] K_DIGIT  = 2'd2;
  localparam logic [1:0] K_CTRL   = 2'd3;

  // Returns {found, ascii[6:0]} for a non-extended make code.
  function automatic logic [7:0] translate(input logic [7:0] code,
                                           input logic       shift,
                                           input logic       caps);
    logic [1:0] kind;
    logic [6:0] lo;
    logic [6:0] hi;
    kind = K_NONE;
    lo   = 7'h00;
    hi   = 7'h00;
    case (code)
      8'h1C: begin kind = K_LETTER; lo = 7'h61; end
      8'h32: begin kind = K_LETTER; lo = 7'h62; end
      8'h21: begin kind = K_LETTER; lo = 7'h63; end
      8'h23: begin kind = K_LETTER; lo = 7'h64; end
      8'h24: begin kind = K_LETTER; lo = 7'h65; end
      8'h2B: begin kind = K_LETTER; lo = 7'h66; end
      8'h34: begin kind = K_LETTER; lo = 7'h67; end
      8'h33: begin kind = K_LETTER; lo = 7'h68; end
      8'h43: begin kind = K_LETTER; lo = 7'h69; end
      8'h3B: begin kind = K_LETTER; lo = 7'h6A; end
      8'h42: begin kind = K_LETTER; lo = 7'h6B; end
      8'h4B: begin kind = K_LETTER; lo = 7'h6C; end
      8'h3A: begin kind = K_LETTER; lo = 7'h6D; end
      8'h31: begin kind = K_LETTER; lo = 7'h6E; end
      8'h44: begin kind = K_LETTER; lo = 7'h6F; end
      8'h4D: begin kind = K_LETTER; lo = 7'h70; end
      8'h15: begin kind = K_LETTER; lo = 7'h71; end
      8'h2D: begin kind = K_LETTER; lo = 7'h72; end
      8'h1B: begin kind = K_LETTER; lo = 7'h73; end
      8'h2C: begin kind = K_LETTER; lo = 7'h74; end
      8'h3C: begin kind = K_LETTER; lo = 7'h75; end
      8'h2A: begin kind = K_LETTER; lo = 7'h76; end
      8'h1D: begin kind = K_LETTER; lo = 7'h77; end
      8'h22: begin kind = K_LETTER; lo = 7'h78; end
      8'h35: begin kind = K_LETTER; lo = 7'h79; end
      8'h1A: begin kind = K_LETTER; lo = 7'h7A; end
      8'h16: begin kind = K_DIGIT; lo = 7'h31; hi = 7'h21; end
      8'h1E: begin kind = K_DIGIT; lo = 7'h32; hi = 7'h40; end
      8'h26: begin kind = K_DIGIT; lo = 7'h33; hi = 7'h23; end
      8'h25: begin kind = K_DIGIT; lo = 7'h34; hi = 7'h24; end
      8'h2E: begin kind = K_DIGIT; lo = 7'h35; hi = 7'h25; end
      8'h36: begin kind = K_DIGIT; lo = 7'h36; hi = 7'h5E; end
      8'h3D: begin kind = K_DIGIT; lo = 7'h37; hi = 7'h26; end
      8'h3E: begin kind = K_DIGIT; lo = 7'h38; hi = 7'h2A; end
      8'h46: begin kind = K_DIGIT; lo = 7'h39; hi = 7'h28; end
      8'h45: begin kind = K_DIGIT; lo = 7'h30; hi = 7'h29; end
      8'h29: begin kind = K_CTRL; lo = 7'h20; end
      8'h5A: begin kind = K_CTRL; lo = 7'h0D; end
      8'h66: begin kind = K_CTRL; lo = 7'h08; end
      8'h0D: begin kind = K_CTRL; lo = 7'h09; end
      8'h76: begin kind = K_CTRL; lo = 7'h1B; end
      default: kind = K_NONE;
    endcase
    case (kind)
      K_LETTER: translate = {1'b1, (shift ^ caps) ? (lo - 7'h20) : lo};
      K_DIGIT:  translate = {1'b1, shift ? hi : lo};
      K_CTRL:   translate = {1'b1, lo};
      default:  translate = 8'h00;
    endcase
  endfunction

  logic       ext_pend;
  logic       brk_pend;
  logic       shl;
  logic       shr;
  logic       caps_q;
  logic       char_valid_q;
  logic [6:0] char_q;
  logic [7:0] xl;

  assign xl         = translate(scan_code, shl | shr, caps_q);
  assign caps_state = caps_q;

  // Decode stage: prefix/modifier tracking and one registered character per make.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_pend     <= 1'b0;
      brk_pend     <= 1'b0;
      shl          <= 1'b0;
      shr          <= 1'b0;
      caps_q       <= 1'b0;
      char_valid_q <= 1'b0;
      char_q       <= 7'h00;
    end else begin
      char_valid_q <= 1'b0;
      if (scan_err) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (scan_valid) begin
        if (scan_code == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (scan_code == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
          if (!ext_pend) begin
            if (scan_code == 8'h12) shl <= !brk_pend;
            if (scan_code == 8'h59) shr <= !brk_pend;
            if (scan_code == 8'h58 && !brk_pend) caps_q <= !caps_q;
            if (!brk_pend) begin
              char_valid_q <= xl[7];
              char_q       <= xl[6:0];
            end
          end
        end
      end
    end
  end

  // cpu_ack is asynchronous: two-flop synchroniser, edge detect, then a
  // registered pop request.
  logic ack_s1;
  logic ack_s2;
  logic ack_prev;
  logic pop_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_s1   <= 1'b0;
      ack_s2   <= 1'b0;
      ack_prev <= 1'b0;
      pop_req  <= 1'b0;
    end else begin
      ack_s1   <= cpu_ack;
      ack_s2   <= ack_s1;
      ack_prev <= ack_s2;
      pop_req  <= ack_s2 & ~ack_prev;
    end
  end

  logic [6:0]            mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_next;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic [6:0]            head_next;

  assign full    = (count == FULL_COUNT);
  assign pop     = pop_req && (count != '0);
  assign push    = char_valid_q && (!full || pop);
  assign rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  // Outputs are registered from the post-update FIFO state, so a char
  // written into an empty FIFO is visible on the very next cycle.
  assign head_next = (push && (wr_ptr == rd_next)) ? char_q : mem[rd_next];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= char_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cpu_intr  <= 1'b0;
      ascii_out <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_next;
      count     <= count_next;
      cpu_intr  <= (count_next != '0);
      ascii_out <= (count_next != '0) ? {1'b0, head_next} : 8'h00;
      if (char_valid_q && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scancode_to_ascii.sv
// Directed bench for scancode_to_ascii: decoding, modifiers, prefix/error
// handling, FIFO full/overflow boundaries and mid-sequence reset.
module tb_scancode_to_ascii;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       scan_err;
  logic       cpu_ack;
  logic       cpu_intr;
  logic [7:0] ascii_out;
  logic       overflow;
  logic       caps_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];

  scancode_to_ascii #(.FIFO_DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .scan_err   (scan_err),
    .cpu_ack    (cpu_ack),
    .cpu_intr   (cpu_intr),
    .ascii_out  (ascii_out),
    .overflow   (overflow),
    .caps_state (caps_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // driver tasks (all return on a negative edge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] code);
    @(negedge clk);
    scan_code  = code;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic send_err(input logic valid, input logic [7:0] code);
    @(negedge clk);
    scan_code  = code;
    scan_valid = valid;
    scan_err   = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    scan_err   = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    cpu_ack = 1'b1;
    idle(3);
    cpu_ack = 1'b0;
    idle(4);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  // scoreboard: pop every expected character through the handshake
  task automatic drain(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_intr"}, {7'd0, cpu_intr}, 8'h01);
      check({tag, "_char"}, ascii_out, e);
      ack_pulse();
    end
    check({tag, "_empty"}, {7'd0, cpu_intr}, 8'h00);
    check({tag, "_zero"}, ascii_out, 8'h00);
  endtask

  initial begin
    rst        = 1'b1;
    scan_code  = 8'h00;
    scan_valid = 1'b0;
    scan_err   = 1'b0;
    cpu_ack    = 1'b0;
    idle(3);
    check("rst_intr", {7'd0, cpu_intr}, 8'h00);
    check("rst_ascii", ascii_out, 8'h00);
    check("rst_ovf", {7'd0, overflow}, 8'h00);
    check("rst_caps", {7'd0, caps_state}, 8'h00);
    rst = 1'b0;
    idle(2);

    // make 1C: latency is exactly two cycles from the strobe cycle
    @(negedge clk);
    scan_code  = 8'h1C;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    check("lat_n1_intr", {7'd0, cpu_intr}, 8'h00);
    @(negedge clk);
    check("lat_n2_intr", {7'd0, cpu_intr}, 8'h01);
    check("lat_n2_char", ascii_out, 8'h61);
    send_byte(8'hF0);
    send_byte(8'h1C);
    idle(3);
    exp_q.push_back(8'h61);
    drain("brk");

    // shifted digit, then release
    send_byte(8'h12);
    send_byte(8'h1E);
    send_byte(8'hF0);
    send_byte(8'h12);
    send_byte(8'h1E);
    idle(3);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h32);
    drain("shift");

    // Caps Lock XOR Shift
    send_byte(8'h58);
    send_byte(8'h1C);
    send_byte(8'h12);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h12);
    idle(3);
    check("caps_on", {7'd0, caps_state}, 8'h01);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h61);
    drain("caps");
    send_byte(8'hF0);
    send_byte(8'h58);
    idle(2);
    check("caps_brk_ign", {7'd0, caps_state}, 8'h01);
    send_byte(8'h58);
    idle(2);
    check("caps_off", {7'd0, caps_state}, 8'h00);

    // extended events, fake shift, error strobes
    send_byte(8'hE0);
    send_byte(8'h5A);
    send_byte(8'hE0);
    send_byte(8'h12);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h12);
    send_byte(8'h16);
    send_err(1'b1, 8'h1C);
    send_byte(8'hF0);
    send_err(1'b0, 8'h00);
    send_byte(8'h1C);
    idle(3);
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h61);
    drain("ext_err");

    // control keys
    send_byte(8'h5A);
    send_byte(8'h66);
    send_byte(8'h0D);
    send_byte(8'h76);
    send_byte(8'h45);
    send_byte(8'h4D);
    idle(3);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h09);
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h70);
    drain("ctrl");

    // overflow: nine spaces into an eight-deep queue
    for (int i = 0; i < 9; i++) send_byte(8'h29);
    idle(3);
    check("ovf_set", {7'd0, overflow}, 8'h01);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h20);
    drain("ovf_drain");
    check("ovf_sticky", {7'd0, overflow}, 8'h01);

    // simultaneous push and pop while full
    apply_reset();
    check("ovf_cleared", {7'd0, overflow}, 8'h00);
    for (int i = 0; i < 8; i++) send_byte(8'h29);
    idle(3);
    check("full_no_ovf", {7'd0, overflow}, 8'h00);
    @(negedge clk);
    cpu_ack = 1'b1;
    idle(2);
    scan_code  = 8'h1C;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    idle(2);
    cpu_ack = 1'b0;
    idle(4);
    check("pp_no_ovf", {7'd0, overflow}, 8'h00);
    for (int i = 0; i < 7; i++) begin
      check("pp_space", ascii_out, 8'h20);
      ack_pulse();
    end
    check("pp_tail_intr", {7'd0, cpu_intr}, 8'h01);
    check("pp_tail_char", ascii_out, 8'h61);

    // reset mid-sequence with caps set and a pending break prefix
    send_byte(8'h58);
    send_byte(8'hF0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_intr", {7'd0, cpu_intr}, 8'h00);
    check("mrst_ascii", ascii_out, 8'h00);
    check("mrst_ovf", {7'd0, overflow}, 8'h00);
    check("mrst_caps", {7'd0, caps_state}, 8'h00);
    rst = 1'b0;
    idle(2);
    send_byte(8'h1C);
    idle(3);
    exp_q.push_back(8'h61);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
